// File: rtl/memory_stage.sv
// MEM stage: issues one data-memory access per EX instruction and
// loads the MEM/WB register, with timeout and misalignment errors.
module memory_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        flush,
    input  logic        AnyStall,
    input  logic [31:0] Result_EX,
    input  logic [31:0] WrDat_EX,
    input  logic [4:0]  WriteReg_EX,
    input  logic        RegWrite_EX,
    input  logic        MemToReg_EX,
    input  logic        MemWrite_EX,
    output logic        DmReq,
    output logic        DmWe,
    output logic [31:0] DmAddr,
    output logic [31:0] DmWdat,
    input  logic        DmAck,
    input  logic [31:0] DmRdat,
    output logic [31:0] Result_MEM,
    output logic [4:0]  WriteReg_MEM,
    output logic        RegWrite_MEM,
    output logic        MemErr_MEM,
    output logic        Stall_MEM
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          tmo_q;
    logic [31:0]   ld_buf;

    logic        access;
    logic        misal;
    logic        ack_ok;
    logic        tmo_hit;
    logic        err;
    logic [31:0] ld_data;

    assign access  = MemToReg_EX | MemWrite_EX;
    assign misal   = Result_EX[1:0] != 2'b00;
    assign DmReq   = (state == IDLE && access && !misal) || state == WAIT;
    assign DmWe    = DmReq & MemWrite_EX;
    assign DmAddr  = Result_EX;
    assign DmWdat  = WrDat_EX;
    assign Stall_MEM = DmReq & ~DmAck;

    // An ack is only meaningful while a request is outstanding
    assign ack_ok  = DmReq & DmAck;
    assign tmo_hit = state == WAIT && !DmAck && cnt == CW'(TIMEOUT - 1);
    assign err     = access & (misal | (state == DONE & tmo_q));
    assign ld_data = ack_ok ? DmRdat : ld_buf;

    always_ff @(posedge clk) begin
        if (flush) begin
            state        <= IDLE;
            cnt          <= '0;
            tmo_q        <= 1'b0;
            ld_buf       <= '0;
            Result_MEM   <= '0;
            WriteReg_MEM <= '0;
            RegWrite_MEM <= 1'b0;
            MemErr_MEM   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (access && !misal) begin
                        if (!DmAck) begin
                            state <= WAIT;
                            cnt   <= '0;
                        end else if (AnyStall) begin
                            state <= DONE;
                        end
                    end
                end
                WAIT: begin
                    if (DmAck) begin
                        cnt   <= '0;
                        state <= AnyStall ? DONE : IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (tmo_hit) begin
                            state <= DONE;
                            tmo_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!AnyStall) begin
                        state <= IDLE;
                        tmo_q <= 1'b0;
                        cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (!AnyStall && !access) begin
                state <= IDLE;
                tmo_q <= 1'b0;
                cnt   <= '0;
            end

            // Hold load data until the pipeline is free to capture it
            if (ack_ok && AnyStall && MemToReg_EX)
                ld_buf <= DmRdat;

            if (!AnyStall) begin
                Result_MEM   <= MemToReg_EX ? ld_data : Result_EX;
                WriteReg_MEM <= WriteReg_EX;
                RegWrite_MEM <= RegWrite_EX & ~err;
                MemErr_MEM   <= err;
            end else begin
                RegWrite_MEM <= 1'b0;
                MemErr_MEM   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: drives EX instructions, plays the
// data memory with programmable latency and checks MEM/WB captures.
module tb_memory_stage;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        flush;
    logic        ext_stall;
    logic        any_stall;
    logic [31:0] Result_EX, WrDat_EX;
    logic [4:0]  WriteReg_EX;
    logic        RegWrite_EX, MemToReg_EX, MemWrite_EX;
    logic        DmReq, DmWe;
    logic [31:0] DmAddr, DmWdat;
    logic        DmAck;
    logic [31:0] DmRdat;
    logic [31:0] Result_MEM;
    logic [4:0]  WriteReg_MEM;
    logic        RegWrite_MEM, MemErr_MEM, Stall_MEM;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rw;
        logic        err;
        logic        chk_res;
    } exp_t;

    exp_t sb[$];

    assign any_stall = ext_stall | Stall_MEM;

    always #5 clk = ~clk;

    memory_stage #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .flush        (flush),
        .AnyStall     (any_stall),
        .Result_EX    (Result_EX),
        .WrDat_EX     (WrDat_EX),
        .WriteReg_EX  (WriteReg_EX),
        .RegWrite_EX  (RegWrite_EX),
        .MemToReg_EX  (MemToReg_EX),
        .MemWrite_EX  (MemWrite_EX),
        .DmReq        (DmReq),
        .DmWe         (DmWe),
        .DmAddr       (DmAddr),
        .DmWdat       (DmWdat),
        .DmAck        (DmAck),
        .DmRdat       (DmRdat),
        .Result_MEM   (Result_MEM),
        .WriteReg_MEM (WriteReg_MEM),
        .RegWrite_MEM (RegWrite_MEM),
        .MemErr_MEM   (MemErr_MEM),
        .Stall_MEM    (Stall_MEM)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // lat: DmReq cycles before ack (-1 = never); hold: stall cycles from ack
    task automatic run_op(input logic ld, input logic st,
                          input logic [31:0] addr, input logic [31:0] wdat,
                          input logic [4:0] rd, input logic rw,
                          input int lat, input logic [31:0] rdat,
                          input int hold, input logic stray);
        exp_t e;
        logic acc, mis, tmo, err, exp_req, cap, done;
        int nreq, nack, hold_left, cyc, want_req;
        acc = ld | st;
        mis = addr[1:0] != 2'b00;
        tmo = acc && !mis && (lat < 0 || lat > TMO);
        err = acc && (mis || tmo);
        e.res = ld ? rdat : addr;
        e.rd = rd;
        e.rw = rw && !err;
        e.err = err;
        e.chk_res = !err;
        sb.push_back(e);
        want_req = (!acc || mis) ? 0 : (tmo ? TMO + 1 : lat + 1);
        nreq = 0; nack = 0; hold_left = 0; cyc = 0; done = 1'b0;
        Result_EX = addr; WrDat_EX = wdat; WriteReg_EX = rd;
        RegWrite_EX = rw; MemToReg_EX = ld; MemWrite_EX = st;
        DmAck = 1'b0;
        while (!done) begin
            #1;
            exp_req = acc && !mis && nack == 0 && nreq < TMO + 1;
            if (exp_req && nreq == lat) begin
                DmAck = 1'b1;
                DmRdat = rdat;
                hold_left = hold;
            end else if (!exp_req && stray) begin
                DmAck = 1'b1;
                DmRdat = 32'hDEAD_BEEF;
            end
            ext_stall = hold_left > 0;
            #1;
            check("dmreq", DmReq, exp_req);
            check("stall", Stall_MEM, exp_req & ~DmAck);
            if (DmReq) begin
                check("addr", DmAddr, addr);
                check("we", DmWe, st);
                if (st) check("wdat", DmWdat, wdat);
                nreq++;
            end
            if (DmReq && DmAck) nack++;
            cap = !any_stall;
            @(posedge clk);
            #1;
            DmAck = 1'b0;
            if (hold_left > 0) hold_left--;
            ext_stall = hold_left > 0;
            if (cap) begin
                e = sb.pop_front();
                if (e.chk_res) check("result", Result_MEM, e.res);
                check("rd", WriteReg_MEM, e.rd);
                check("regwrite", RegWrite_MEM, e.rw);
                check("memerr", MemErr_MEM, e.err);
                done = 1'b1;
            end else begin
                check("bubble_rw", RegWrite_MEM, 0);
                check("bubble_err", MemErr_MEM, 0);
            end
            cyc++;
            if (!done && cyc > 64) begin
                check("cycle_budget", 0, 1);
                done = 1'b1;
            end
        end
        check("req_cycles", nreq, want_req);
        check("acks", nack, (want_req > 0 && !tmo) ? 1 : 0);
    endtask

    initial begin
        flush = 1'b1; ext_stall = 1'b0; DmAck = 1'b0; DmRdat = '0;
        Result_EX = '0; WrDat_EX = '0; WriteReg_EX = '0;
        RegWrite_EX = 1'b0; MemToReg_EX = 1'b0; MemWrite_EX = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", Result_MEM, 0);
        check("rst_rd", WriteReg_MEM, 0);
        check("rst_rw", RegWrite_MEM, 0);
        check("rst_err", MemErr_MEM, 0);
        check("rst_req", DmReq, 0);
        flush = 1'b0;

        run_op(0, 0, 32'h1234, 0, 5'd3, 1, 0, 0, 0, 0);
        run_op(1, 0, 32'h100, 0, 5'd5, 1, 0, 32'hCAFEF00D, 0, 0);
        run_op(0, 1, 32'h204, 32'h55, 5'd0, 0, 3, 0, 0, 0);
        run_op(1, 0, 32'h300, 0, 5'd7, 1, 1, 32'hA5A51234, 3, 0);
        run_op(1, 0, 32'h308, 0, 5'd8, 1, 0, 32'h0BAD_F00D, 2, 0);
        run_op(1, 0, 32'h102, 0, 5'd9, 1, 0, 32'h1111_2222, 0, 0);
        run_op(0, 1, 32'h207, 32'h77, 5'd0, 0, 0, 0, 0, 0);
        run_op(1, 0, 32'h400, 0, 5'd10, 1, -1, 0, 0, 0);
        run_op(0, 0, 32'h5555, 0, 5'd11, 1, 0, 0, 0, 1);

        for (int i = 0; i < 6; i++) begin
            logic is_ld;
            logic [31:0] a;
            is_ld = 1'($urandom_range(0, 1));
            a = $urandom() & 32'hFFFF_FFFC;
            run_op(is_ld, !is_ld, a, $urandom(), 5'($urandom_range(1, 31)),
                   is_ld, $urandom_range(0, 4), $urandom(),
                   $urandom_range(0, 2), 0);
        end

        // Abort a load in its fifth WAIT cycle
        Result_EX = 32'h500; MemToReg_EX = 1'b1; RegWrite_EX = 1'b1;
        WriteReg_EX = 5'd12; MemWrite_EX = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("wait5_req", DmReq, 1);
        flush = 1'b1;
        Result_EX = '0; MemToReg_EX = 1'b0; RegWrite_EX = 1'b0;
        WriteReg_EX = '0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("fl_result", Result_MEM, 0);
        check("fl_rd", WriteReg_MEM, 0);
        check("fl_rw", RegWrite_MEM, 0);
        check("fl_err", MemErr_MEM, 0);
        check("fl_req", DmReq, 0);
        check("fl_stall", Stall_MEM, 0);

        run_op(0, 0, 32'h6000, 0, 5'd13, 1, 0, 0, 0, 1);
        run_op(1, 0, 32'h600, 0, 5'd14, 1, 2, 32'h1357_9BDF, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
